// File: rtl/regfile_wr_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
package regfile_wr_sched_pkg;
  localparam logic [3:0] RNONE     = 4'hf;
  localparam logic [3:0] RRSP      = 4'h4;
  localparam int         WBQ_DEPTH = 4;

  typedef struct packed {
    logic [3:0]  addr;
    logic [63:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/regfile_wr_sched_wbq.sv
// Circular buffer of pending register writes: 0/1/2 pushes and one pop per cycle.
module regfile_wr_sched_wbq
  import regfile_wr_sched_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             push_n_i,
  input  wbq_entry_t             push0_i,
  input  wbq_entry_t             push1_i,
  input  logic                   pop_i,
  output logic [AW:0]            count_o,
  output logic [AW-1:0]          head_o,
  output wbq_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]       valid_o
);
  wbq_entry_t [DEPTH-1:0] mem_q;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    head_d  = pop_i ? head_q + AW'(1) : head_q;
    tail_d  = tail_q + AW'(push_n_i);
    count_d = count_q + (AW+1)'(push_n_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed through valid_o / count.
  always_ff @(posedge clk_i) begin
    if (push_n_i != 2'd0) mem_q[tail_q] <= push0_i;
    if (push_n_i == 2'd2) mem_q[tail_q + AW'(1)] <= push1_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    assign valid_o[i] = {1'b0, AW'(AW'(i) - head_q)} < count_q;
  end

  assign count_o   = count_q;
  assign head_o    = head_q;
  assign entries_o = mem_q;
endmodule

// File: rtl/regfile_wr_sched.sv
// Write-back scheduler: queues E/M writes, retires one per cycle, forwards queued values to decode.
module regfile_wr_sched
  import regfile_wr_sched_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  output logic        wb_ready_o,
  input  logic [3:0]  dstE_i,
  input  logic [63:0] valE_i,
  input  logic [3:0]  dstM_i,
  input  logic [63:0] valM_i,
  output logic        wr_en_o,
  output logic [3:0]  wr_addr_o,
  output logic [63:0] wr_data_o,
  input  logic [3:0]  rd_addr_a_i,
  input  logic [3:0]  rd_addr_b_i,
  output logic        fwd_hit_a_o,
  output logic [63:0] fwd_data_a_o,
  output logic        fwd_hit_b_o,
  output logic [63:0] fwd_data_b_o,
  output logic        empty_o
);
  logic [AW:0]            count;
  logic [AW-1:0]          head;
  wbq_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]       valid;
  logic                   e_en, m_en, accept;
  logic [1:0]             n_enq, push_n;
  wbq_entry_t             push0, push1;

  // M wins when both halves target the same register (popq %rsp).
  assign e_en   = (dstE_i != RNONE) && (dstE_i != dstM_i);
  assign m_en   = (dstM_i != RNONE);
  assign n_enq  = 2'(e_en) + 2'(m_en);
  assign accept = wb_valid_i && wb_ready_o;
  assign push_n = accept ? n_enq : 2'd0;
  assign push0  = e_en ? '{addr: dstE_i, data: valE_i} : '{addr: dstM_i, data: valM_i};
  assign push1  = '{addr: dstM_i, data: valM_i};

  regfile_wr_sched_wbq #(.DEPTH(DEPTH), .AW(AW)) u_wbq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_n_i  (push_n),
    .push0_i   (push0),
    .push1_i   (push1),
    .pop_i     (wr_en_o),
    .count_o   (count),
    .head_o    (head),
    .entries_o (entries),
    .valid_o   (valid)
  );

  assign wb_ready_o = count <= (AW+1)'(DEPTH - 2);
  assign empty_o    = (count == '0);
  assign wr_en_o    = (count != '0);
  assign wr_addr_o  = wr_en_o ? entries[head].addr : RNONE;
  assign wr_data_o  = wr_en_o ? entries[head].data : 64'd0;

  // Scan oldest to newest so the last match is the newest queued value.
  always_comb begin
    logic [AW-1:0] idx;
    idx          = '0;
    fwd_hit_a_o  = 1'b0;
    fwd_data_a_o = 64'd0;
    fwd_hit_b_o  = 1'b0;
    fwd_data_b_o = 64'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (valid[idx] && rd_addr_a_i != RNONE && entries[idx].addr == rd_addr_a_i) begin
        fwd_hit_a_o  = 1'b1;
        fwd_data_a_o = entries[idx].data;
      end
      if (valid[idx] && rd_addr_b_i != RNONE && entries[idx].addr == rd_addr_b_i) begin
        fwd_hit_b_o  = 1'b1;
        fwd_data_b_o = entries[idx].data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched with hand-computed expectations.
module tb_regfile_wr_sched;
  logic        clk = 1'b0;
  logic        rst_i, wb_valid_i, wb_ready_o;
  logic [3:0]  dstE_i, dstM_i, wr_addr_o, rd_addr_a_i, rd_addr_b_i;
  logic [63:0] valE_i, valM_i, wr_data_o, fwd_data_a_o, fwd_data_b_o;
  logic        wr_en_o, fwd_hit_a_o, fwd_hit_b_o, empty_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wr_sched dut (
    .clk_i(clk), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .dstE_i(dstE_i), .valE_i(valE_i), .dstM_i(dstM_i), .valM_i(valM_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_addr_a_i(rd_addr_a_i), .rd_addr_b_i(rd_addr_b_i),
    .fwd_hit_a_o(fwd_hit_a_o), .fwd_data_a_o(fwd_data_a_o),
    .fwd_hit_b_o(fwd_hit_b_o), .fwd_data_b_o(fwd_data_b_o),
    .empty_o(empty_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [3:0] de, input logic [63:0] ve,
                     input logic [3:0] dm, input logic [63:0] vm);
    wb_valid_i = v; dstE_i = de; valE_i = ve; dstM_i = dm; valM_i = vm;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] a, input logic [63:0] d);
    chk({tag, ".en"}, 64'(wr_en_o), 64'(en));
    chk({tag, ".addr"}, 64'(wr_addr_o), 64'(a));
    chk({tag, ".data"}, wr_data_o, d);
  endtask

  logic [67:0] expq[$];
  logic [67:0] front;
  int  cnt, nreq, nwr;
  bit  acc, saw_stall;

  initial begin
    rst_i = 1'b1; rd_addr_a_i = 4'h3; rd_addr_b_i = 4'h4;
    req(1'b0, 4'hf, 64'd0, 4'hf, 64'd0);
    step(); step();
    chk_wr("reset", 1'b0, 4'hf, 64'd0);
    chk("reset.empty", 64'(empty_o), 64'd1);
    chk("reset.ready", 64'(wb_ready_o), 64'd1);
    chk("reset.hit_a", 64'(fwd_hit_a_o), 64'd0);
    chk("reset.data_a", fwd_data_a_o, 64'd0);
    chk("reset.hit_b", 64'(fwd_hit_b_o), 64'd0);
    rst_i = 1'b0;

    // rrmovq: single E write
    req(1'b1, 4'h3, 64'h11, 4'hf, 64'd0);
    step(); req(1'b0, 4'hf, 64'd0, 4'hf, 64'd0); #1;
    chk_wr("rrmov.w", 1'b1, 4'h3, 64'h11);
    chk("rrmov.hit_a", 64'(fwd_hit_a_o), 64'd1);
    chk("rrmov.data_a", fwd_data_a_o, 64'h11);
    chk("rrmov.empty", 64'(empty_o), 64'd0);
    step();
    chk("rrmov.idle_en", 64'(wr_en_o), 64'd0);
    chk("rrmov.idle_empty", 64'(empty_o), 64'd1);

    // popq %rbx: E then M; in-flight request is not forwarded
    req(1'b1, 4'h4, 64'h108, 4'h3, 64'hAB); #1;
    chk("rbx.nofwd_req", 64'(fwd_hit_b_o), 64'd0);
    step(); req(1'b0, 4'hf, 64'd0, 4'hf, 64'd0); #1;
    chk_wr("rbx.w0", 1'b1, 4'h4, 64'h108);
    chk("rbx.hit_b0", 64'(fwd_hit_b_o), 64'd1);
    chk("rbx.data_b0", fwd_data_b_o, 64'h108);
    chk("rbx.data_a0", fwd_data_a_o, 64'hAB);
    step();
    chk_wr("rbx.w1", 1'b1, 4'h3, 64'hAB);
    chk("rbx.hit_b1", 64'(fwd_hit_b_o), 64'd0);
    step();
    chk("rbx.empty", 64'(empty_o), 64'd1);

    // popq %rsp: M wins, single write
    req(1'b1, 4'h4, 64'h108, 4'h4, 64'h55);
    step(); req(1'b0, 4'hf, 64'd0, 4'hf, 64'd0); #1;
    chk_wr("rsp.w", 1'b1, 4'h4, 64'h55);
    chk("rsp.data_b", fwd_data_b_o, 64'h55);
    step();
    chk("rsp.once_en", 64'(wr_en_o), 64'd0);
    chk("rsp.empty", 64'(empty_o), 64'd1);

    // both halves none: accepted, no effect
    req(1'b1, 4'hf, 64'h1, 4'hf, 64'h2);
    step(); req(1'b0, 4'hf, 64'd0, 4'hf, 64'd0); #1;
    chk("none.en", 64'(wr_en_o), 64'd0);
    chk("none.empty", 64'(empty_o), 64'd1);

    // back-to-back two-write requests against a reference count model
    cnt = 0; nreq = 0; nwr = 0; saw_stall = 0;
    for (int cyc = 0; cyc < 40 && !(nreq == 4 && cnt == 0); cyc++) begin
      if (nreq < 4) req(1'b1, 4'(nreq), 64'h1000 + 64'(nreq), 4'(nreq + 8), 64'h2000 + 64'(nreq));
      else          req(1'b0, 4'hf, 64'd0, 4'hf, 64'd0);
      #1;
      chk("b2b.ready", 64'(wb_ready_o), 64'(cnt <= 2));
      if (cnt > 2) saw_stall = 1;
      if (cnt != 0) begin
        front = expq.pop_front();
        chk("b2b.en", 64'(wr_en_o), 64'd1);
        chk("b2b.addr", 64'(wr_addr_o), 64'(front[67:64]));
        chk("b2b.data", wr_data_o, front[63:0]);
        nwr++;
      end
      acc = wb_valid_i && (cnt <= 2);
      if (acc) begin
        expq.push_back({4'(nreq), 64'h1000 + 64'(nreq)});
        expq.push_back({4'(nreq + 8), 64'h2000 + 64'(nreq)});
      end
      step();
      cnt = cnt + (acc ? 2 : 0) - ((cnt != 0) ? 1 : 0);
      if (acc) nreq++;
    end
    chk("b2b.writes", 64'(nwr), 64'd8);
    chk("b2b.stalled", 64'(saw_stall), 64'd1);
    chk("b2b.empty", 64'(empty_o), 64'd1);

    // forwarding picks the newest of two queued writes to r2
    rd_addr_a_i = 4'h2; rd_addr_b_i = 4'h7;
    req(1'b1, 4'h7, 64'h77, 4'h2, 64'hA);
    step();
    req(1'b1, 4'h2, 64'hB, 4'hf, 64'd0);
    step(); req(1'b0, 4'hf, 64'd0, 4'hf, 64'd0); #1;
    chk("fwd.hit_a", 64'(fwd_hit_a_o), 64'd1);
    chk("fwd.data_a", fwd_data_a_o, 64'hB);
    chk("fwd.hit_b_popped", 64'(fwd_hit_b_o), 64'd0);
    chk_wr("fwd.head", 1'b1, 4'h2, 64'hA);
    rd_addr_a_i = 4'hf; #1;
    chk("fwd.none_hit", 64'(fwd_hit_a_o), 64'd0);
    chk("fwd.none_data", fwd_data_a_o, 64'd0);
    step(); step();
    chk("fwd.empty", 64'(empty_o), 64'd1);

    // reset with three entries queued
    rd_addr_a_i = 4'h1; rd_addr_b_i = 4'h9;
    req(1'b1, 4'h1, 64'h1, 4'h9, 64'h9);
    step();
    req(1'b1, 4'ha, 64'ha, 4'hb, 64'hb);
    step(); req(1'b0, 4'hf, 64'd0, 4'hf, 64'd0); #1;
    chk("mid.pre_ready", 64'(wb_ready_o), 64'd0);
    rst_i = 1'b1;
    step(); rst_i = 1'b0; #1;
    chk_wr("mid.rst", 1'b0, 4'hf, 64'd0);
    chk("mid.empty", 64'(empty_o), 64'd1);
    chk("mid.ready", 64'(wb_ready_o), 64'd1);
    chk("mid.hit_b", 64'(fwd_hit_b_o), 64'd0);
    step();
    chk("mid.no_more", 64'(wr_en_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
